// File: rtl/skin_det_pkg.sv
// Shared constants and types for the skin mask / bounding box pipeline.
// Holds default widths, Cb/Cr thresholds, ycbcr field offsets and helpers.
package skin_det_pkg;

  localparam int SYNC_DLY_DEF = 2;
  localparam int X_W_DEF      = 11;
  localparam int Y_W_DEF      = 11;
  localparam int CNT_W_DEF    = 20;

  localparam int CB_MIN_DEF   = 77;
  localparam int CB_MAX_DEF   = 127;
  localparam int CR_MIN_DEF   = 133;
  localparam int CR_MAX_DEF   = 173;
  localparam int MIN_PIX_DEF  = 256;

  localparam int CH_W   = 8;
  localparam int PIX_W  = 24;
  localparam int Y_LSB  = 16;
  localparam int CB_LSB = 8;
  localparam int CR_LSB = 0;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  function automatic logic in_rng(
    input logic [CH_W-1:0] v,
    input logic [CH_W-1:0] lo,
    input logic [CH_W-1:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/skin_bbox_detect_if.sv
// Stream bundle: raw timing + ycbcr in, mask stream and box results out.
// master = upstream source / result consumer, slave = skin_bbox_detect.
interface skin_bbox_if
  import skin_det_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             in_vsync;
  logic             in_hsync;
  logic             in_de;
  logic [PIX_W-1:0] ycbcr;

  logic             bin_vsync;
  logic             bin_hsync;
  logic             bin_de;
  logic             bin_pix;

  logic             box_valid;
  logic             box_found;
  logic [X_W-1:0]   box_x_min;
  logic [X_W-1:0]   box_x_max;
  logic [Y_W-1:0]   box_y_min;
  logic [Y_W-1:0]   box_y_max;
  logic [CNT_W-1:0] pix_cnt;

  modport master (
    output in_vsync, in_hsync, in_de, ycbcr,
    input  bin_vsync, bin_hsync, bin_de, bin_pix,
    input  box_valid, box_found,
    input  box_x_min, box_x_max,
    input  box_y_min, box_y_max,
    input  pix_cnt
  );

  modport slave (
    input  in_vsync, in_hsync, in_de, ycbcr,
    output bin_vsync, bin_hsync, bin_de, bin_pix,
    output box_valid, box_found,
    output box_x_min, box_x_max,
    output box_y_min, box_y_max,
    output pix_cnt
  );

endinterface

// File: rtl/skin_bbox_detect_sync_delay_line.sv
// N-stage by W-bit shift register with async reset for pixel timing.
// Ports: clk, rst_n, d_i (W) in, q_o (W) = d_i delayed N cycles.
module sync_delay_line
  import skin_det_pkg::*;
#(
  parameter int W = 3,
  parameter int N = SYNC_DLY_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stg_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < N; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[N-1];

endmodule

// File: rtl/skin_bbox_detect.sv
// Cb/Cr skin mask with per-frame bounding box and pixel count.
// Ports: clk, rst_n, bus (skin_bbox_if.slave: timing/ycbcr in, mask/box out).
module skin_bbox_detect
  import skin_det_pkg::*;
#(
  parameter int SYNC_DLY = SYNC_DLY_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CB_MIN   = CB_MIN_DEF,
  parameter int CB_MAX   = CB_MAX_DEF,
  parameter int CR_MIN   = CR_MIN_DEF,
  parameter int CR_MAX   = CR_MAX_DEF,
  parameter int MIN_PIX  = MIN_PIX_DEF
) (
  input logic      clk,
  input logic      rst_n,
  skin_bbox_if.slave bus
);

  localparam logic [X_W-1:0]   X_MAX = {X_W{1'b1}};
  localparam logic [Y_W-1:0]   Y_MAX = {Y_W{1'b1}};
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  sync_t sync_in;
  sync_t sync_d;

  assign sync_in = '{vs: bus.in_vsync,
                     hs: bus.in_hsync,
                     de: bus.in_de};

  sync_delay_line #(
    .W ($bits(sync_t)),
    .N (SYNC_DLY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_in),
    .q_o   (sync_d)
  );

  logic [CH_W-1:0] cb;
  logic [CH_W-1:0] cr;
  logic            unused_y;
  logic            hit;

  assign cb       = bus.ycbcr[CB_LSB +: CH_W];
  assign cr       = bus.ycbcr[CR_LSB +: CH_W];
  assign unused_y = ^bus.ycbcr[Y_LSB +: CH_W];

  assign hit = sync_d.de
             & in_rng(cb, CH_W'(CB_MIN), CH_W'(CB_MAX))
             & in_rng(cr, CH_W'(CR_MIN), CR_W_MAX());

  function automatic logic [CH_W-1:0] CR_W_MAX();
    return CH_W'(CR_MAX);
  endfunction

  logic vs_p_q;
  logic de_p_q;
  logic vs_rise;
  logic de_fall;

  assign vs_rise = sync_d.vs & ~vs_p_q;
  assign de_fall = ~sync_d.de & de_p_q;

  sync_t            bin_q;
  logic             bin_pix_q;

  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [X_W-1:0]   xmin_q, xmin_d;
  logic [X_W-1:0]   xmax_q, xmax_d;
  logic [Y_W-1:0]   ymin_q, ymin_d;
  logic [Y_W-1:0]   ymax_q, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  logic             valid_q, valid_d;
  logic             found_q, found_d;
  logic [X_W-1:0]   oxmin_q, oxmin_d;
  logic [X_W-1:0]   oxmax_q, oxmax_d;
  logic [Y_W-1:0]   oymin_q, oymin_d;
  logic [Y_W-1:0]   oymax_q, oymax_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic             latch;

  always_comb begin
    x_d = x_q;
    if (sync_d.de) begin
      if (x_q != X_MAX) x_d = x_q + 1'b1;
    end else if (de_fall) begin
      x_d = '0;
    end

    y_d = y_q;
    if (vs_rise) begin
      y_d = '0;
    end else if (de_fall && (y_q != Y_MAX)) begin
      y_d = y_q + 1'b1;
    end

    // Clear first so a hit on the boundary cycle opens the new frame.
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (vs_rise) begin
      xmin_d = '1;
      xmax_d = '0;
      ymin_d = '1;
      ymax_d = '0;
      cnt_d  = '0;
    end
    if (hit) begin
      if (x_q < xmin_d) xmin_d = x_q;
      if (x_q > xmax_d) xmax_d = x_q;
      if (y_q < ymin_d) ymin_d = y_q;
      if (y_q > ymax_d) ymax_d = y_q;
      if (cnt_d != C_MAX) cnt_d = cnt_d + 1'b1;
    end

    seen_d = seen_q | vs_rise;

    // The partial frame before the first boundary is discarded.
    latch   = vs_rise & seen_q;
    valid_d = latch;
    found_d = found_q;
    oxmin_d = oxmin_q;
    oxmax_d = oxmax_q;
    oymin_d = oymin_q;
    oymax_d = oymax_q;
    ocnt_d  = ocnt_q;
    if (latch) begin
      found_d = (cnt_q >= CNT_W'(MIN_PIX));
      ocnt_d  = cnt_q;
      if (cnt_q != '0) begin
        oxmin_d = xmin_q;
        oxmax_d = xmax_q;
        oymin_d = ymin_q;
        oymax_d = ymax_q;
      end else begin
        oxmin_d = '0;
        oxmax_d = '0;
        oymin_d = '0;
        oymax_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_p_q    <= 1'b0;
      de_p_q    <= 1'b0;
      bin_q     <= '0;
      bin_pix_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      xmin_q    <= '1;
      xmax_q    <= '0;
      ymin_q    <= '1;
      ymax_q    <= '0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      oxmin_q   <= '0;
      oxmax_q   <= '0;
      oymin_q   <= '0;
      oymax_q   <= '0;
      ocnt_q    <= '0;
    end else begin
      vs_p_q    <= sync_d.vs;
      de_p_q    <= sync_d.de;
      bin_q     <= sync_d;
      bin_pix_q <= hit;
      x_q       <= x_d;
      y_q       <= y_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      found_q   <= found_d;
      oxmin_q   <= oxmin_d;
      oxmax_q   <= oxmax_d;
      oymin_q   <= oymin_d;
      oymax_q   <= oymax_d;
      ocnt_q    <= ocnt_d;
    end
  end

  assign bus.bin_vsync = bin_q.vs;
  assign bus.bin_hsync = bin_q.hs;
  assign bus.bin_de    = bin_q.de;
  assign bus.bin_pix   = bin_pix_q;
  assign bus.box_valid = valid_q;
  assign bus.box_found = found_q;
  assign bus.box_x_min = oxmin_q;
  assign bus.box_x_max = oxmax_q;
  assign bus.box_y_min = oymin_q;
  assign bus.box_y_max = oymax_q;
  assign bus.pix_cnt   = ocnt_q;

endmodule

// File: tb/tb_skin_bbox_detect.sv
// Directed bench for skin_bbox_detect: two DUTs (MIN_PIX 4 and 8)
// share one stimulus stream; ycbcr is fed two cycles after timing.
module tb_skin_bbox_detect;
  import skin_det_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skin_bbox_if ifa ();
  skin_bbox_if ifb ();

  skin_bbox_detect #(.MIN_PIX(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  skin_bbox_detect #(.MIN_PIX(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [23:0] p0 = '0;
  logic [23:0] p1 = '0;
  logic        v1;
  logic        v2;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; ycbcr lags timing by two calls.
  task automatic drive(input logic vs, input logic hs,
                       input logic de,
                       input logic [7:0] cb,
                       input logic [7:0] cr);
    @(negedge clk);
    ifa.in_vsync = vs;
    ifa.in_hsync = hs;
    ifa.in_de    = de;
    ifa.ycbcr    = p1;
    ifb.in_vsync = vs;
    ifb.in_hsync = hs;
    ifb.in_de    = de;
    ifb.ycbcr    = p1;
    p1 = p0;
    p0 = {8'h55, cb, cr};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic hsync();
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
  endtask

  // mode 0: all skin, 1: skin at x 2..4 / y 1..2, 2: none
  task automatic line(input int row, input int mode);
    logic h;
    hsync();
    for (int c = 0; c < 8; c++) begin
      h = (mode == 0) ||
          (mode == 1 && c >= 2 && c <= 4 && row >= 1 && row <= 2);
      drive(1'b0, 1'b0, 1'b1, h ? 8'd100 : 8'd50, 8'd150);
    end
    idle();
    idle();
  endtask

  task automatic frame(input int mode);
    for (int r = 0; r < 4; r++) line(r, mode);
  endtask

  // box_valid is visible 3 calls after in_vsync first rises.
  task automatic vs_edge(output logic a, output logic b);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    a = ifa.box_valid;
    idle();
    b = ifa.box_valid;
    idle();
    idle();
  endtask

  initial begin
    ifa.in_vsync = 1'b0;
    ifa.in_hsync = 1'b0;
    ifa.in_de    = 1'b0;
    ifa.ycbcr    = '0;
    ifb.in_vsync = 1'b0;
    ifb.in_hsync = 1'b0;
    ifb.in_de    = 1'b0;
    ifb.ycbcr    = '0;

    repeat (5) drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd150);
    chk("rst_bin_de", ifa.bin_de, 0);
    chk("rst_bin_pix", ifa.bin_pix, 0);
    chk("rst_valid", ifa.box_valid, 0);
    chk("rst_cnt", ifa.pix_cnt, 0);
    chk("rst_xmin", ifa.box_x_min, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd150);
    drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd150);
    idle();
    idle();

    frame(0);
    vs_edge(v1, v2);
    chk("first_vs_valid", v1, 0);
    chk("first_vs_valid_n1", v2, 0);

    frame(0);
    vs_edge(v1, v2);
    chk("full_valid", v1, 1);
    chk("full_pulse_end", v2, 0);
    chk("full_xmin", ifa.box_x_min, 0);
    chk("full_xmax", ifa.box_x_max, 7);
    chk("full_ymin", ifa.box_y_min, 0);
    chk("full_ymax", ifa.box_y_max, 3);
    chk("full_cnt", ifa.pix_cnt, 32);
    chk("full_found4", ifa.box_found, 1);
    chk("full_found8", ifb.box_found, 1);

    frame(1);
    vs_edge(v1, v2);
    chk("sub_valid", v1, 1);
    chk("sub_xmin", ifa.box_x_min, 2);
    chk("sub_xmax", ifa.box_x_max, 4);
    chk("sub_ymin", ifa.box_y_min, 1);
    chk("sub_ymax", ifa.box_y_max, 2);
    chk("sub_cnt", ifa.pix_cnt, 6);
    chk("sub_found4", ifa.box_found, 1);
    chk("sub_found8", ifb.box_found, 0);

    hsync();
    drive(1'b0, 1'b0, 1'b1, 8'd77, 8'd133);
    drive(1'b0, 1'b0, 1'b1, 8'd76, 8'd150);
    drive(1'b0, 1'b0, 1'b1, 8'd127, 8'd173);
    chk("lat_early_de", ifa.bin_de, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd128, 8'd150);
    chk("lat_de", ifa.bin_de, 1);
    chk("thr_77_133", ifa.bin_pix, 1);
    drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd174);
    chk("thr_76_150", ifa.bin_pix, 0);
    idle();
    chk("thr_127_173", ifa.bin_pix, 1);
    idle();
    chk("thr_128_150", ifa.bin_pix, 0);
    idle();
    chk("thr_100_174", ifa.bin_pix, 0);
    idle();
    chk("lat_de_end", ifa.bin_de, 0);
    vs_edge(v1, v2);
    chk("thr_valid", v1, 1);
    chk("thr_xmin", ifa.box_x_min, 0);
    chk("thr_xmax", ifa.box_x_max, 2);
    chk("thr_ymax", ifa.box_y_max, 0);
    chk("thr_cnt", ifa.pix_cnt, 2);
    chk("thr_found4", ifa.box_found, 0);

    line(0, 0);
    line(1, 0);
    hsync();
    repeat (4) drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd150);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bin_de", ifa.bin_de, 0);
    chk("mid_rst_cnt", ifa.pix_cnt, 0);
    chk("mid_rst_xmax", ifa.box_x_max, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd150);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd150);
    idle();
    idle();
    line(3, 0);
    vs_edge(v1, v2);
    chk("mid_rst_nopulse", v1, 0);
    chk("mid_rst_nopulse_n1", v2, 0);
    chk("mid_rst_cnt_hold", ifa.pix_cnt, 0);

    frame(1);
    vs_edge(v1, v2);
    chk("post_rst_valid", v1, 1);
    chk("post_rst_xmin", ifa.box_x_min, 2);
    chk("post_rst_xmax", ifa.box_x_max, 4);
    chk("post_rst_ymin", ifa.box_y_min, 1);
    chk("post_rst_ymax", ifa.box_y_max, 2);
    chk("post_rst_cnt", ifa.pix_cnt, 6);

    frame(2);
    vs_edge(v1, v2);
    chk("empty_valid", v1, 1);
    chk("empty_cnt", ifa.pix_cnt, 0);
    chk("empty_found", ifa.box_found, 0);
    chk("empty_xmin", ifa.box_x_min, 0);
    chk("empty_xmax", ifa.box_x_max, 0);
    chk("empty_ymin", ifa.box_y_min, 0);
    chk("empty_ymax", ifa.box_y_max, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
